// File: rtl/irq_controller_if.sv
// ---------------------------------------------------------------------------
// irq_controller_if
// Data-memory bus bundle for the interrupt controller.
//   addr_i        : byte address from the CPU dmem port
//   read_enable_i : read strobe
//   write_mask_i  : byte write mask (only the full mask 4'b1111 writes)
//   write_data_i  : write data
//   read_data_o   : registered read data, valid the cycle after the strobe
// Modports: master = CPU side, slave = controller side.
// ---------------------------------------------------------------------------
interface irq_controller_if;
  logic [31:0] addr_i;
  logic        read_enable_i;
  logic [3:0]  write_mask_i;
  logic [31:0] write_data_i;
  logic [31:0] read_data_o;

  modport master (
    output addr_i,
    output read_enable_i,
    output write_mask_i,
    output write_data_i,
    input  read_data_o
  );

  modport slave (
    input  addr_i,
    input  read_enable_i,
    input  write_mask_i,
    input  write_data_i,
    output read_data_o
  );
endinterface

// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
// Memory-mapped interrupt controller driving the CPU interrupt input.
// Collects SOURCES request lines (level or rising-edge), latches them into
// PENDING, masks with ENABLE/INSERVICE and raises a registered interrupt.
// The handler claims the lowest-numbered ready source via a CLAIM read and
// retires it with a COMPLETE write.
//
// Ports:
//   clk_i      : clock
//   reset_n_i  : synchronous active-low reset
//   sources_i  : raw request lines, source i reports id i+1 (id 0 = none)
//   bus        : dmem slave port (addr/read strobe/write mask/data/read data)
//   interrupt_o: registered interrupt request
//
// Register window (BASE_ADDR, 32-byte aligned), word offsets:
//   0x00 PENDING (R/W1C, edge sources only)  0x04 ENABLE  0x08 EDGE
//   0x0C CLAIM (R, side effecting)           0x10 COMPLETE (W)  0x14 INSERVICE
//
// Build option: define IRQ_SYNC_EN to put a 2-flop synchroniser on every
// source line (adds 2 cycles of latency); undefined, sources_i must already
// be synchronous to clk_i.
// ---------------------------------------------------------------------------
module irq_controller #(
  parameter int unsigned SOURCES   = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFF00_0100
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [SOURCES-1:0] sources_i,
  irq_controller_if.slave    bus,
  output logic               interrupt_o
);

  typedef enum logic [2:0] {
    OFF_PENDING   = 3'd0,
    OFF_ENABLE    = 3'd1,
    OFF_EDGE      = 3'd2,
    OFF_CLAIM     = 3'd3,
    OFF_COMPLETE  = 3'd4,
    OFF_INSERVICE = 3'd5
  } reg_off_t;

  logic [SOURCES-1:0] r_pending;
  logic [SOURCES-1:0] r_enable;
  logic [SOURCES-1:0] r_edge;
  logic [SOURCES-1:0] r_inservice;
  logic [SOURCES-1:0] r_prev;
  logic [31:0]        r_read_data;
  logic               r_irq;

  logic [SOURCES-1:0] w_s;
  logic               w_sel;
  logic [2:0]         w_off;
  logic               w_wr;
  logic               w_rd;
  logic               w_claim;
  logic [SOURCES-1:0] w_avail;
  logic [4:0]         w_claim_id;
  logic [SOURCES-1:0] w_claim_oh;
  logic [SOURCES-1:0] w_claim_set;
  logic [4:0]         w_cpl_id;
  logic [SOURCES-1:0] w_cpl_clr;
  logic [SOURCES-1:0] w_w1c;
  logic [SOURCES-1:0] w_rise;
  logic [SOURCES-1:0] w_pending_nxt;
  logic [SOURCES-1:0] w_inservice_nxt;
  logic [31:0]        w_rdata;
  logic               w_unused;

  // -------------------------------------------------------------------------
  // Source sampling
  // -------------------------------------------------------------------------
`ifdef IRQ_SYNC_EN
  logic [SOURCES-1:0] r_sync1;
  logic [SOURCES-1:0] r_sync2;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sources_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = sources_i;
`endif

  // -------------------------------------------------------------------------
  // Bus decode
  // -------------------------------------------------------------------------
  assign w_sel   = (bus.addr_i[31:5] == BASE_ADDR[31:5]);
  assign w_off   = bus.addr_i[4:2];
  assign w_wr    = w_sel && (bus.write_mask_i == 4'b1111);
  assign w_rd    = w_sel && bus.read_enable_i;
  assign w_claim = w_rd && (w_off == OFF_CLAIM);

  // Low address bits and upper write-data bits carry no meaning here.
  assign w_unused = ^{bus.addr_i[1:0], bus.write_data_i};

  // -------------------------------------------------------------------------
  // Claim arbitration: lowest ready index wins
  // -------------------------------------------------------------------------
  assign w_avail = r_pending & r_enable & ~r_inservice;

  always_comb begin
    w_claim_id = '0;
    w_claim_oh = '0;
    for (int unsigned i = 0; i < SOURCES; i++) begin
      if (w_avail[i] && (w_claim_id == '0)) begin
        w_claim_id    = 5'(i + 1);
        w_claim_oh[i] = 1'b1;
      end
    end
  end

  assign w_claim_set = w_claim ? w_claim_oh : '0;

  // COMPLETE decodes the written id into a one-hot clear; id 0 or an id past
  // SOURCES matches no bit and so has no effect.
  assign w_cpl_id = bus.write_data_i[4:0];

  always_comb begin
    w_cpl_clr = '0;
    for (int unsigned i = 0; i < SOURCES; i++) begin
      w_cpl_clr[i] = w_wr && (w_off == OFF_COMPLETE) && (w_cpl_id == 5'(i + 1));
    end
  end

  assign w_w1c  = (w_wr && (w_off == OFF_PENDING)) ? bus.write_data_i[SOURCES-1:0] : '0;
  assign w_rise = w_s & ~r_prev;

  // Edge bits: clear terms applied first, then a new rising edge forces the
  // bit set so a same-cycle edge is never lost. Level bits track s.
  assign w_pending_nxt = (r_edge & ((r_pending & ~w_w1c & ~w_claim_set) | w_rise))
                       | (~r_edge & w_s);

  // Claim set is OR'ed after the COMPLETE clear so it wins on the same id.
  assign w_inservice_nxt = (r_inservice & ~w_cpl_clr) | w_claim_set;

  // -------------------------------------------------------------------------
  // Read mux (pre-write register values)
  // -------------------------------------------------------------------------
  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_PENDING:   w_rdata[SOURCES-1:0] = r_pending;
      OFF_ENABLE:    w_rdata[SOURCES-1:0] = r_enable;
      OFF_EDGE:      w_rdata[SOURCES-1:0] = r_edge;
      OFF_CLAIM:     w_rdata[4:0]         = w_claim_id;
      OFF_INSERVICE: w_rdata[SOURCES-1:0] = r_inservice;
      default:       w_rdata = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_pending   <= '0;
      r_enable    <= '0;
      r_edge      <= '0;
      r_inservice <= '0;
      r_prev      <= '0;
      r_read_data <= '0;
      r_irq       <= 1'b0;
    end else begin
      r_pending   <= w_pending_nxt;
      r_inservice <= w_inservice_nxt;
      r_prev      <= w_s;
      r_irq       <= |w_avail;
      r_read_data <= w_rd ? w_rdata : '0;
      if (w_wr && (w_off == OFF_ENABLE)) r_enable <= bus.write_data_i[SOURCES-1:0];
      if (w_wr && (w_off == OFF_EDGE))   r_edge   <= bus.write_data_i[SOURCES-1:0];
    end
  end

  assign bus.read_data_o = r_read_data;
  assign interrupt_o     = r_irq;

endmodule

// File: tb/tb_irq_controller.sv
// ---------------------------------------------------------------------------
// tb_irq_controller
// Self-checking bench for irq_controller: directed scenarios with fixed
// expected values, then randomized bus/source traffic compared cycle by
// cycle against a per-source behavioural model of the register rules.
// ---------------------------------------------------------------------------
module tb_irq_controller;
  localparam int unsigned S    = 8;
  localparam logic [31:0] BASE = 32'hFF00_0100;
`ifdef IRQ_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [S-1:0] src;
  logic         irq;

  irq_controller_if bus ();

  irq_controller #(.SOURCES(S), .BASE_ADDR(BASE)) dut (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .sources_i   (src),
    .bus         (bus),
    .interrupt_o (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [S-1:0] m_pend, m_en, m_edge, m_insv, m_prev;
  logic [S-1:0] m_sync[$];
  logic [31:0]  m_rdata;
  logic         m_irq;

  task automatic model_reset();
    m_pend = '0; m_en = '0; m_edge = '0; m_insv = '0; m_prev = '0;
    m_rdata = '0; m_irq = 1'b0;
    m_sync.delete();
    for (int i = 0; i < L; i++) m_sync.push_back('0);
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic [S-1:0] s, n_pend, n_insv, ready;
    logic [31:0]  rv;
    logic         sel, wr, claim;
    int           off, id, cid;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (L == 0) s = src;
    else begin
      s = m_sync.pop_front();
      m_sync.push_back(src);
    end
    sel   = (bus.addr_i[31:5] == BASE[31:5]);
    off   = int'(bus.addr_i[4:2]);
    wr    = sel && (bus.write_mask_i == 4'hF);
    claim = sel && bus.read_enable_i && (off == 3);
    ready = m_pend & m_en & ~m_insv;
    id = 0;
    for (int i = 0; i < S; i++) if (ready[i] && id == 0) id = i + 1;
    rv = 0;
    if (sel && bus.read_enable_i) begin
      case (off)
        0: rv = 32'(m_pend);
        1: rv = 32'(m_en);
        2: rv = 32'(m_edge);
        3: rv = 32'(id);
        5: rv = 32'(m_insv);
        default: rv = 0;
      endcase
    end
    cid = int'(bus.write_data_i[4:0]);
    n_pend = m_pend;
    n_insv = m_insv;
    for (int i = 0; i < S; i++) begin
      if (m_edge[i]) begin
        if (wr && off == 0 && bus.write_data_i[i]) n_pend[i] = 1'b0;
        if (claim && id == i + 1) n_pend[i] = 1'b0;
        if (s[i] && !m_prev[i]) n_pend[i] = 1'b1;
      end else begin
        n_pend[i] = s[i];
      end
      if (wr && off == 4 && cid == i + 1) n_insv[i] = 1'b0;
      if (claim && id == i + 1) n_insv[i] = 1'b1;
    end
    m_irq   = (ready != 0);
    m_rdata = rv;
    m_pend  = n_pend;
    m_insv  = n_insv;
    if (wr && off == 1) m_en   = bus.write_data_i[S-1:0];
    if (wr && off == 2) m_edge = bus.write_data_i[S-1:0];
    m_prev = s;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    bus.addr_i        = BASE;
    bus.read_enable_i = 1'b0;
    bus.write_mask_i  = 4'h0;
    bus.write_data_i  = '0;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("rdata", bus.read_data_o, m_rdata);
    check("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic wr(input int off, input logic [31:0] d);
    bus.addr_i = BASE + 32'(off * 4);
    bus.read_enable_i = 1'b0;
    bus.write_mask_i = 4'hF;
    bus.write_data_i = d;
    cyc();
    idle();
  endtask

  task automatic rd(input int off, output logic [31:0] v);
    bus.addr_i = BASE + 32'(off * 4);
    bus.read_enable_i = 1'b1;
    bus.write_mask_i = 4'h0;
    cyc();
    v = bus.read_data_o;
    idle();
  endtask

  logic [31:0] v;

  initial begin
    rst_n = 1'b0;
    src = '1;
    model_reset();
    idle();

    // Reset with sources high and a CLAIM read strobed
    bus.addr_i = BASE + 32'hC;
    bus.read_enable_i = 1'b1;
    repeat (3) cyc();
    check("rst_irq", 32'(irq), 0);
    check("rst_rdata", bus.read_data_o, 0);
    idle();
    src = '0;
    rst_n = 1'b1;
    rd(0, v); check("rst_pend", v, 0);
    rd(1, v); check("rst_en", v, 0);
    rd(2, v); check("rst_edge", v, 0);
    rd(5, v); check("rst_insv", v, 0);

    // Edge source 0, one-cycle pulse
    wr(2, 1);
    wr(1, 1);
    src = 8'h01;
    cyc();
    src = '0;
    repeat (L) cyc();
    check("edge_irq_early", 32'(irq), 0);
    cyc();
    check("edge_irq_on", 32'(irq), 1);
    rd(0, v); check("edge_pend", v, 1);
    rd(3, v); check("edge_claim", v, 1);
    rd(0, v); check("edge_pend_clr", v, 0);
    check("edge_irq_off", 32'(irq), 0);
    rd(5, v); check("edge_insv", v, 1);
    wr(4, 1);
    rd(5, v); check("edge_complete", v, 0);

    // Priority between level sources 2 and 5
    wr(2, 0);
    wr(1, 32'h24);
    src = 8'h24;
    repeat (L + 2) cyc();
    check("prio_irq", 32'(irq), 1);
    rd(3, v); check("prio_claim3", v, 3);
    rd(3, v); check("prio_claim6", v, 6);
    rd(3, v); check("prio_claim0", v, 0);
    cyc();
    check("prio_irq_off", 32'(irq), 0);
    wr(4, 3);
    cyc();
    check("prio_reassert", 32'(irq), 1);
    wr(4, 6);
    src = '0;
    wr(1, 0);
    repeat (L + 2) cyc();

    // Masking on edge source 1
    wr(2, 32'h02);
    src = 8'h02;
    cyc();
    src = '0;
    repeat (L + 3) cyc();
    check("mask_irq", 32'(irq), 0);
    rd(3, v); check("mask_claim", v, 0);
    wr(1, 32'h02);
    check("mask_irq_wr", 32'(irq), 0);
    cyc();
    check("mask_irq_on", 32'(irq), 1);
    rd(3, v); check("mask_claim2", v, 2);
    wr(4, 2);
    wr(1, 0);

    // Rising edge on source 0 in the same cycle as W1C of bit 0
    wr(2, 32'h01);
    src = 8'h01;
    repeat (L) cyc();
    wr(0, 32'h01);
    src = '0;
    rd(0, v); check("coll_set_wins", v, 1);
    wr(0, 32'h01);
    rd(0, v); check("coll_w1c", v, 0);

    // Partial-mask write ignored
    wr(1, 32'h5A);
    bus.addr_i = BASE + 32'h4;
    bus.write_mask_i = 4'b0011;
    bus.write_data_i = 32'h0F;
    cyc();
    idle();
    rd(1, v); check("partial_mask", v, 32'h5A);
    wr(1, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int op;
      int off;
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) src = src ^ (S'($urandom) & S'($urandom) & S'($urandom));
      idle();
      op  = $urandom_range(0, 7);
      off = (op < 2) ? 3 : $urandom_range(0, 7);
      bus.addr_i = ($urandom_range(0, 9) == 0) ? $urandom : BASE + 32'(off * 4);
      if (op < 4) bus.read_enable_i = 1'b1;
      if (op >= 4 && op < 7) begin
        bus.write_mask_i = ($urandom_range(0, 6) == 0) ? 4'($urandom) : 4'hF;
        bus.write_data_i = (off == 4) ? 32'($urandom_range(0, 10)) : $urandom;
      end
      if (op == 7) begin
        bus.read_enable_i = 1'b1;
        bus.write_mask_i = 4'hF;
        bus.write_data_i = $urandom;
      end
      cyc();
    end
    idle();
    repeat (4) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
